// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: one command in, one pixel per cycle out,
// optional clipping to the visible screen rectangle.
module line_draw_engine #(
    parameter int XW       = 11,
    parameter int YW       = 10,
    parameter int CW       = 16,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 480,
    parameter int CLIP_EN  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] color,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_color,
    output logic          pix_last,
    output logic          busy,
    output logic          done,
    output logic [XW:0]   pix_count
);

    localparam int W = ((XW > YW) ? XW : YW) + 2;
    localparam logic [XW:0] SW_L = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH_L = (YW+1)'(SCREEN_H);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nx;

    logic [XW-1:0]       px, ex, px_nx;
    logic [YW-1:0]       py, ey, py_nx;
    logic [CW-1:0]       col;
    logic signed [W-1:0] dx, dy, err;
    logic                sx_neg, sy_neg;
    logic                done_r;
    logic [XW:0]         cnt;

    logic signed [W-1:0] xd, yd, adx, ady, e2, err_nx;
    logic                step_x, step_y;
    logic                onscr, at_end, pv, advance, accept;

    // Endpoint deltas for a new command, and the per-cycle Bresenham step
    always_comb begin
        xd     = W'(x1) - W'(x0);
        yd     = W'(y1) - W'(y0);
        adx    = xd[W-1] ? -xd : xd;
        ady    = yd[W-1] ? -yd : yd;
        e2     = err <<< 1;
        step_x = (e2 > dy);
        step_y = (e2 < dx);
        err_nx = err;
        px_nx  = px;
        py_nx  = py;
        if (step_x) begin
            err_nx = err_nx + dy;
            px_nx  = sx_neg ? px - XW'(1) : px + XW'(1);
        end
        if (step_y) begin
            err_nx = err_nx + dx;
            py_nx  = sy_neg ? py - YW'(1) : py + YW'(1);
        end
    end

    // Visibility, endpoint detection and the advance qualifier
    always_comb begin
        onscr   = (CLIP_EN == 0) ||
                  (({1'b0, px} < SW_L) && ({1'b0, py} < SH_L));
        at_end  = (px == ex) && (py == ey);
        pv      = (state == RUN) && onscr;
        advance = (state == RUN) && (!pv || pix_ready);
        accept  = (state == IDLE) && cmd_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: leave RUN only when the endpoint is consumed
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (cmd_valid)         state_nx = RUN;
            RUN:  if (advance && at_end) state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // Datapath: capture command, walk the line, count handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            px     <= '0;
            py     <= '0;
            ex     <= '0;
            ey     <= '0;
            col    <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= advance && at_end;
            if (accept) begin
                px     <= x0;
                py     <= y0;
                ex     <= x1;
                ey     <= y1;
                col    <= color;
                dx     <= adx;
                dy     <= -ady;
                err    <= adx - ady;
                sx_neg <= (x1 < x0);
                sy_neg <= (y1 < y0);
                cnt    <= '0;
            end else begin
                if (advance && !at_end) begin
                    px  <= px_nx;
                    py  <= py_nx;
                    err <= err_nx;
                end
                if (pv && pix_ready) cnt <= cnt + (XW+1)'(1);
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign pix_valid = pv;
    assign pix_last  = pv && at_end;
    assign pix_x     = px;
    assign pix_y     = py;
    assign pix_color = col;
    assign done      = done_r;
    assign pix_count = cnt;

endmodule
